pipeline_ctrl: RTL and testbench

//  Central pipeline controller for the 5-stage MIPS core.
//  - Merges per-stage stall requests into the 6-bit stall vector (PC/IF/ID/EX/MEM/WB) used by every pipeline register.
//  - Sequences exception/ERET recovery: freezes the pipe, then issues a one-cycle flush with the redirect address (new_pc) to the PC register.
//  - Masks re-detection of an exception while recovery is in progress.

---
 rtl/pipeline_ctrl_pkg.sv | 34 +++
 rtl/pipeline_ctrl_stall_encoder.sv | 21 ++
 rtl/pipeline_ctrl.sv | 116 +++++++++++
 tb/tb_pipeline_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall masks, exception codes, FSM states.
// Latency: n/a (definitions only). Backpressure: n/a.
package pipeline_ctrl_pkg;

  // Each mask freezes the requesting stage and everything upstream of it (bit0 = PC .. bit5 = WB).
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  localparam logic [31:0] EXC_NONE     = 32'h0000_0000;
  localparam logic [31:0] EXC_INT      = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL  = 32'h0000_0008;
  localparam logic [31:0] EXC_INV_INST = 32'h0000_000A;
  localparam logic [31:0] EXC_OV       = 32'h0000_000C;
  localparam logic [31:0] EXC_TRAP     = 32'h0000_000D;
  localparam logic [31:0] EXC_ERET     = 32'h0000_000E;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } ctrl_state_e;

  // ERET returns to the saved EPC; every other exception enters the common handler.
  function automatic logic [31:0] exc_target(input logic [31:0] exc,
                                             input logic [31:0] epc,
                                             input logic [31:0] vec);
    return (exc == EXC_ERET) ? epc : vec;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_encoder.sv
// Priority encoder: four stage stall requests to a 6-bit stall mask, latest stage wins.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module pipeline_ctrl_stall_encoder
  import pipeline_ctrl_pkg::*;
(
  input  logic       req_if_i,
  input  logic       req_id_i,
  input  logic       req_ex_i,
  input  logic       req_mem_i,
  output logic [5:0] mask_o
);

  always_comb begin
    mask_o = STALL_NONE;
    if (req_mem_i)     mask_o = STALL_MEM;
    else if (req_ex_i) mask_o = STALL_EX;
    else if (req_id_i) mask_o = STALL_ID;
    else if (req_if_i) mask_o = STALL_IF;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: merges stall requests and sequences exception/ERET flush+redirect; optional PIPE_CTRL_PERF_EN perf counters.
// Latency: stall same cycle, flush/new_pc one cycle after detection. Backpressure: stall_o freezes pipeline registers.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles_o,
  output logic [15:0] perf_flush_count_o
`endif
);
  import pipeline_ctrl_pkg::*;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  ctrl_state_e state_q;
  logic        flush_q;
  logic [31:0] new_pc_q;
  logic [3:0]  hold_cnt_q;
  logic [5:0]  enc_mask;
  logic        exc_vld;

  assign exc_vld = (excepttype_i != EXC_NONE);

  pipeline_ctrl_stall_encoder u_stall_encoder (
    .req_if_i  (stallreq_if_i),
    .req_id_i  (stallreq_id_i),
    .req_ex_i  (stallreq_ex_i),
    .req_mem_i (stallreq_mem_i),
    .mask_o    (enc_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      flush_q    <= 1'b0;
      new_pc_q   <= 32'h0;
      hold_cnt_q <= 4'd0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (exc_vld) begin
            state_q  <= ST_FLUSH;
            flush_q  <= 1'b1;
            new_pc_q <= exc_target(excepttype_i, cp0_epc_i, EXC_VECTOR);
          end
        end
        ST_FLUSH: begin
          hold_cnt_q <= 4'd0;
          state_q    <= (HOLD_CYCLES == 0) ? ST_RUN : ST_HOLD;
        end
        ST_HOLD: begin
          // Exceptions seen here belong to the flushed instruction stream and are dropped.
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_q <= 4'd0;
            state_q    <= ST_RUN;
          end else begin
            hold_cnt_q <= hold_cnt_q + 4'd1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    stall_o = STALL_NONE;
    if (!rst) begin
      case (state_q)
        ST_RUN:  stall_o = exc_vld ? STALL_ALL : enc_mask;
        ST_HOLD: stall_o = enc_mask;
        default: stall_o = STALL_NONE;
      endcase
    end
  end

  assign flush_o  = flush_q;
  assign new_pc_o = new_pc_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + ((stall_o != STALL_NONE) ? 32'd1 : 32'd0);
    perf_flush_d = perf_flush_q + {15'd0, flush_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 16'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cycles_o = perf_stall_q;
  assign perf_flush_count_o  = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed steps then random traffic against a cycle-timestamp reference model.
// Latency: n/a. Backpressure: n/a.
module tb_pipeline_ctrl;

  localparam logic [31:0] VEC  = 32'hBFC0_0380;
  localparam int          HOLD = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles_o;
  logic [15:0] perf_flush_count_o;
  logic [31:0] m_stall_cnt = 32'd0;
  logic [15:0] m_flush_cnt = 16'd0;
`endif

  int          checks   = 0;
  int          failures = 0;
  // Reference model: absolute cycle numbers of the pending flush and of the first cycle an exception is accepted again.
  int          cyc         = 0;
  int          flush_at    = -1;
  int          accept_from = 0;
  logic [31:0] m_pc        = 32'h0;
  logic [31:0] codes [7];

  pipeline_ctrl #(.EXC_VECTOR(VEC), .HOLD_CYCLES(HOLD)) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_if_i  (stallreq_if_i),
    .stallreq_id_i  (stallreq_id_i),
    .stallreq_ex_i  (stallreq_ex_i),
    .stallreq_mem_i (stallreq_mem_i),
    .excepttype_i   (excepttype_i),
    .cp0_epc_i      (cp0_epc_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles_o (perf_stall_cycles_o),
    .perf_flush_count_o  (perf_flush_count_o)
`endif
  );

  always #5 clk = ~clk;

  // Highest requesting stage k (0=IF..3=MEM) stalls itself and all k+1 stages before it: 2^(k+2)-1.
  function automatic logic [5:0] ref_mask(input logic [3:0] req);
    for (int k = 3; k >= 0; k--)
      if (req[k]) return 6'((1 << (k + 2)) - 1);
    return 6'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // req = {mem, ex, id, if}
  task automatic step(input logic r, input logic [31:0] exc, input logic [31:0] epc, input logic [3:0] req);
    logic       exp_flush, acc;
    logic [5:0] exp_stall;
    rst            = r;
    excepttype_i   = exc;
    cp0_epc_i      = epc;
    stallreq_mem_i = req[3];
    stallreq_ex_i  = req[2];
    stallreq_id_i  = req[1];
    stallreq_if_i  = req[0];
    #2;
    exp_flush = (cyc == flush_at);
    acc       = !r && (exc != 32'h0) && (cyc >= accept_from);
    exp_stall = r ? 6'd0 : exp_flush ? 6'd0 : acc ? 6'h3F : ref_mask(req);
    chk("stall",  {26'd0, stall_o}, {26'd0, exp_stall});
    chk("flush",  {31'd0, flush_o}, {31'd0, exp_flush});
    chk("new_pc", new_pc_o, m_pc);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall", perf_stall_cycles_o, m_stall_cnt);
    chk("perf_flush", {16'd0, perf_flush_count_o}, {16'd0, m_flush_cnt});
`endif
    if (r) begin
      flush_at    = -1;
      accept_from = 0;
      m_pc        = 32'h0;
`ifdef PIPE_CTRL_PERF_EN
      m_stall_cnt = 32'd0;
      m_flush_cnt = 16'd0;
`endif
    end else begin
`ifdef PIPE_CTRL_PERF_EN
      if (exp_stall != 6'd0) m_stall_cnt = m_stall_cnt + 32'd1;
      if (exp_flush)         m_flush_cnt = m_flush_cnt + 16'd1;
`endif
      if (acc) begin
        flush_at    = cyc + 1;
        accept_from = cyc + 2 + HOLD;
        m_pc        = (exc == 32'hE) ? epc : VEC;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic        r;
    logic [31:0] exc;
    codes[0] = 32'h1; codes[1] = 32'h8; codes[2] = 32'hA;
    codes[3] = 32'hC; codes[4] = 32'hD; codes[5] = 32'hE; codes[6] = 32'h0;
    rst = 1'b1; excepttype_i = 32'h0; cp0_epc_i = 32'h0;
    stallreq_if_i = 1'b0; stallreq_id_i = 1'b0; stallreq_ex_i = 1'b0; stallreq_mem_i = 1'b1;
    @(posedge clk);
    #1;

    // Reset holds stalls off even with a MEM request; release exposes it at once.
    step(1'b1, 32'h0, 32'h0, 4'b1000);
    step(1'b0, 32'h0, 32'h0, 4'b1000);
    // IF+EX together, then nothing.
    step(1'b0, 32'h0, 32'h0, 4'b0101);
    step(1'b0, 32'h0, 32'h0, 4'b0000);
    // Syscall to the exception vector.
    step(1'b0, 32'h8, 32'h0, 4'b0000);
    repeat (3) step(1'b0, 32'h0, 32'h0, 4'b0000);
    // ERET returns to EPC.
    step(1'b0, 32'hE, 32'hBFC0_0100, 4'b0000);
    repeat (3) step(1'b0, 32'h0, 32'h0, 4'b0000);
    // Exception held continuously alongside a MEM stall: only one accepted per recovery window.
    repeat (6) step(1'b0, 32'h8, 32'h0, 4'b1000);
    repeat (2) step(1'b0, 32'h0, 32'h0, 4'b0000);
    // Reset during FLUSH aborts recovery; the very next exception is taken.
    step(1'b0, 32'hC, 32'h0, 4'b0000);
    step(1'b1, 32'h0, 32'h0, 4'b0000);
    step(1'b0, 32'h1, 32'h0, 4'b0000);
    repeat (4) step(1'b0, 32'h0, 32'h0, 4'b0000);
    // Ten stalled cycles from a clean reset.
    step(1'b1, 32'h0, 32'h0, 4'b0000);
    repeat (10) step(1'b0, 32'h0, 32'h0, 4'b1000);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_ten", perf_stall_cycles_o, 32'd10);
`endif
    step(1'b0, 32'h0, 32'h0, 4'b0000);

    for (int i = 0; i < 500; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      exc = 32'h0;
      if ($urandom_range(0, 4) == 0) begin
        exc = codes[$urandom_range(0, 6)];
        if (exc == 32'h0) exc = $urandom | 32'h100;
      end
      step(r, exc, $urandom, 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
